pet_state_eval: RTL and testbench

- Parametrised successor of the plant-pet mood evaluator.
- Takes NUM_NEEDS packed need levels plus a resting flag and produces the 4-bit mood code consumed by the display/sprite logic.
- Adds per-channel state mapping, tick-gated evaluation, hysteresis (a new mood must persist for HOLD_CYCLES ticks), sticky death, a change pulse, and diagnostic low-need outputs.

---
 rtl/pet_state_eval.sv | 164 ++++++++++++++++
 tb/tb_pet_state_eval.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pet_state_eval.sv
// pet_state_eval: turns packed need levels plus a resting flag into the committed 4-bit mood
// code for the display/sprite logic. Moods are filtered through a tick-gated hold counter,
// death is sticky until reset, and per-channel low flags are exported for diagnostics.
module pet_state_eval #(
    parameter int unsigned NUM_NEEDS   = 5,
    parameter int unsigned NEED_W      = 3,
    parameter int unsigned LOW_TH      = 5,
    parameter int unsigned CRIT_TH     = 3,
    parameter int unsigned DEATH_TH    = 2,
    parameter int unsigned DEPR_COUNT  = 2,
    parameter int unsigned DESOL_COUNT = 3,
    parameter int unsigned DEATH_COUNT = 4,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter logic [4*NUM_NEEDS-1:0] NEED_STATE = 20'h26754
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick,
    input  logic [NUM_NEEDS*NEED_W-1:0]   needs,
    input  logic                          resting,
    output logic [3:0]                    estado,
    output logic                          estado_changed,
    output logic [NUM_NEEDS-1:0]          low_mask,
    output logic [$clog2(NUM_NEEDS)-1:0]  dominant_need
);

    localparam int unsigned CntW  = $clog2(NUM_NEEDS + 1);
    localparam int unsigned DomW  = $clog2(NUM_NEEDS);
    localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_CYCLES);

    typedef enum logic [3:0] {
        Bien         = 4'd0,
        Excelente    = 4'd1,
        Cansada      = 4'd2,
        Reposada     = 4'd3,
        Desnutrida   = 4'd4,
        Deshidratada = 4'd5,
        Descuidada   = 4'd6,
        Remontada    = 4'd7,
        Desolada     = 4'd8,
        Depresion    = 4'd9,
        Muerte       = 4'd10
    } mood_e;

    logic [NUM_NEEDS-1:0] low_flag, crit_flag, fatal_flag;
    logic [CntW-1:0]      low_cnt, crit_cnt, fatal_cnt;
    logic [DomW-1:0]      dom;
    logic [3:0]           first_state;
    mood_e                cand;
    logic [HoldW-1:0]     hold_inc;

    mood_e                estado_q, cand_q;
    logic                 changed_q;
    logic [NUM_NEEDS-1:0] low_mask_q;
    logic [DomW-1:0]      dom_q;
    logic [HoldW-1:0]     hold_q;

    // Per-channel threshold flags and their population counts.
    always_comb begin
        low_flag   = '0;
        crit_flag  = '0;
        fatal_flag = '0;
        low_cnt    = '0;
        crit_cnt   = '0;
        fatal_cnt  = '0;
        for (int i = 0; i < int'(NUM_NEEDS); i++) begin
            low_flag[i]   = 32'(needs[i*NEED_W +: NEED_W]) < LOW_TH;
            crit_flag[i]  = 32'(needs[i*NEED_W +: NEED_W]) < CRIT_TH;
            fatal_flag[i] = 32'(needs[i*NEED_W +: NEED_W]) < DEATH_TH;
            if (low_flag[i])   low_cnt   = low_cnt + 1'b1;
            if (crit_flag[i])  crit_cnt  = crit_cnt + 1'b1;
            if (fatal_flag[i]) fatal_cnt = fatal_cnt + 1'b1;
        end
    end

    // Lowest-index low channel and its mapped mood; scanning downward lets the lowest win.
    always_comb begin
        dom         = '0;
        first_state = '0;
        for (int i = int'(NUM_NEEDS) - 1; i >= 0; i--) begin
            if (low_flag[i]) begin
                dom         = DomW'(i);
                first_state = NEED_STATE[i*4 +: 4];
            end
        end
    end

    // Candidate mood from the current levels, first match wins.
    always_comb begin
        if (32'(fatal_cnt) >= DEATH_COUNT) begin
            cand = Muerte;
        end else if (32'(crit_cnt) >= DESOL_COUNT) begin
            cand = Desolada;
        end else if (32'(low_cnt) >= DEPR_COUNT) begin
            cand = Depresion;
        end else if (|low_flag) begin
            cand = mood_e'(first_state);
        end else if (&needs) begin
            cand = Excelente;
        end else begin
            cand = Bien;
        end
        hold_inc = hold_q + 1'b1;
    end

    // Mood state machine: sticky death, resting override, hold-filtered commits.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q   <= Bien;
            cand_q     <= Bien;
            changed_q  <= 1'b0;
            low_mask_q <= '0;
            dom_q      <= '0;
            hold_q     <= '0;
        end else begin
            changed_q <= 1'b0;
            if (tick) begin
                low_mask_q <= low_flag;
                dom_q      <= dom;
                if (estado_q != Muerte) begin
                    if (resting) begin
                        estado_q  <= Reposada;
                        changed_q <= (estado_q != Reposada);
                        cand_q    <= Reposada;
                        hold_q    <= '0;
                    end else if (cand == Muerte) begin
                        estado_q  <= Muerte;
                        changed_q <= 1'b1;
                        cand_q    <= Muerte;
                        hold_q    <= '0;
                    end else if (cand == estado_q) begin
                        cand_q <= cand;
                        hold_q <= '0;
                    end else if (cand == cand_q) begin
                        if (hold_inc == HoldMax) begin
                            estado_q  <= cand;
                            changed_q <= 1'b1;
                            hold_q    <= '0;
                        end else begin
                            hold_q <= hold_inc;
                        end
                    end else begin
                        cand_q <= cand;
                        // A one-tick hold means a fresh candidate commits immediately.
                        if (HoldMax == HoldW'(1)) begin
                            estado_q  <= cand;
                            changed_q <= 1'b1;
                            hold_q    <= '0;
                        end else begin
                            hold_q <= HoldW'(1);
                        end
                    end
                end
            end
        end
    end

    assign estado         = estado_q;
    assign estado_changed = changed_q;
    assign low_mask       = low_mask_q;
    assign dominant_need  = dom_q;

endmodule

// File: tb/tb_pet_state_eval.sv
// Bench for pet_state_eval: two instances (hold of 4 and hold of 1) share stimulus and are
// compared every cycle against a history-based mood model, plus literal spot checks.
module tb_pet_state_eval;

    localparam int NN = 5;
    localparam int W  = 3;
    localparam int NEED_STATE = 32'h26754;

    logic          clk = 1'b0;
    logic          rst, tick, resting;
    logic [14:0]   needs;
    logic [3:0]    est0, est1;
    logic          chg0, chg1;
    logic [4:0]    lm0, lm1;
    logic [2:0]    dom0, dom1;

    always #5 clk = ~clk;

    pet_state_eval #(.HOLD_CYCLES(4)) u_dut (
        .clk(clk), .rst(rst), .tick(tick), .needs(needs), .resting(resting),
        .estado(est0), .estado_changed(chg0), .low_mask(lm0), .dominant_need(dom0)
    );

    pet_state_eval #(.HOLD_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .tick(tick), .needs(needs), .resting(resting),
        .estado(est1), .estado_changed(chg1), .low_mask(lm1), .dominant_need(dom1)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model state: committed mood, pulse, and candidate history since the last event.
    int m_est[2];
    int m_chg[2];
    int m_mask;
    int m_dom;
    int hist[2][64];
    int hlen[2];
    int hold_of[2] = '{4, 1};

    function automatic logic [14:0] mk(int n0, int n1, int n2, int n3, int n4);
        return {3'(n4), 3'(n3), 3'(n2), 3'(n1), 3'(n0)};
    endfunction

    function automatic int level(logic [14:0] nd, int i);
        return int'(nd[i*W +: W]);
    endfunction

    function automatic int cand_of(logic [14:0] nd);
        int lows = 0, crits = 0, fatals = 0, first = -1, allmax = 1;
        for (int i = 0; i < NN; i++) begin
            int lv = level(nd, i);
            if (lv < 5) begin
                lows++;
                if (first < 0) first = i;
            end
            if (lv < 3) crits++;
            if (lv < 2) fatals++;
            if (lv != 7) allmax = 0;
        end
        if (fatals >= 4) return 10;
        if (crits >= 3) return 8;
        if (lows >= 2) return 9;
        if (first >= 0) return (NEED_STATE >> (4 * first)) & 15;
        if (allmax != 0) return 1;
        return 0;
    endfunction

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic model_step();
        int c, run, mask, dom;
        mask = 0;
        dom  = 0;
        for (int i = NN - 1; i >= 0; i--) begin
            if (level(needs, i) < 5) begin
                mask = mask | (1 << i);
                dom  = i;
            end
        end
        if (rst) begin
            m_mask = 0;
            m_dom  = 0;
        end else if (tick) begin
            m_mask = mask;
            m_dom  = dom;
        end
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_est[k] = 0;
                m_chg[k] = 0;
                hlen[k]  = 0;
            end else begin
                m_chg[k] = 0;
                if (tick && m_est[k] != 10) begin
                    if (resting) begin
                        m_chg[k] = (m_est[k] != 3) ? 1 : 0;
                        m_est[k] = 3;
                        hlen[k]  = 0;
                    end else begin
                        c = cand_of(needs);
                        if (c == 10) begin
                            m_chg[k] = 1;
                            m_est[k] = 10;
                            hlen[k]  = 0;
                        end else begin
                            if (hlen[k] == 64) begin
                                for (int j = 0; j < 63; j++) hist[k][j] = hist[k][j+1];
                                hlen[k] = 63;
                            end
                            hist[k][hlen[k]] = c;
                            hlen[k]++;
                            run = 0;
                            for (int j = hlen[k] - 1; j >= 0; j--) begin
                                if (hist[k][j] != c) break;
                                run++;
                            end
                            if (c != m_est[k] && run >= hold_of[k]) begin
                                m_chg[k] = 1;
                                m_est[k] = c;
                                hlen[k]  = 0;
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic step(input bit t);
        tick = t;
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    // Compare every cycle once reset has been applied.
    always @(negedge clk) begin
        if (chk_en) begin
            check("estado_h4", int'(est0), m_est[0]);
            check("changed_h4", int'(chg0), m_chg[0]);
            check("low_mask_h4", int'(lm0), m_mask);
            check("dominant_h4", int'(dom0), m_dom);
            check("estado_h1", int'(est1), m_est[1]);
            check("changed_h1", int'(chg1), m_chg[1]);
            check("low_mask_h1", int'(lm1), m_mask);
            check("dominant_h1", int'(dom1), m_dom);
        end
    end

    initial begin
        rst     = 1'b1;
        tick    = 1'b0;
        resting = 1'b0;
        needs   = mk(7, 7, 7, 7, 7);

        // Pin the candidate model with hand-derived values.
        check("model_death", cand_of(mk(1, 1, 1, 1, 7)), 10);
        check("model_desol", cand_of(mk(2, 2, 2, 6, 6)), 8);
        check("model_depr", cand_of(mk(4, 4, 6, 6, 6)), 9);
        check("model_excel", cand_of(mk(7, 7, 7, 7, 7)), 1);
        check("model_ch2", cand_of(mk(6, 6, 3, 6, 6)), 7);
        check("model_bien", cand_of(mk(6, 6, 6, 6, 6)), 0);

        // 1: reset, then excellent needs commit after four ticks.
        step(1'b0);
        step(1'b0);
        chk_en = 1'b1;
        check("reset_estado", int'(est0), 0);
        check("reset_mask", int'(lm0), 0);
        rst = 1'b0;
        step(1'b1);
        check("t1_tick1_h4", int'(est0), 0);
        check("t1_tick1_h1", int'(est1), 1);
        check("t1_pulse_h1", int'(chg1), 1);
        step(1'b1);
        step(1'b1);
        check("t1_tick3_h4", int'(est0), 0);
        step(1'b1);
        check("t1_tick4_h4", int'(est0), 1);
        check("t1_pulse_h4", int'(chg0), 1);
        step(1'b0);
        check("t1_pulse_end", int'(chg0), 0);

        // 2: one low channel.
        needs = mk(4, 6, 6, 6, 6);
        step(1'b1);
        check("t2_mask", int'(lm0), 1);
        check("t2_dom", int'(dom0), 0);
        check("t2_h1", int'(est1), 4);
        step(1'b1);
        step(1'b1);
        check("t2_tick3", int'(est0), 1);
        step(1'b1);
        check("t2_tick4", int'(est0), 4);

        // 3: settle to BIEN, then a flickering candidate never commits.
        needs = mk(6, 6, 6, 6, 6);
        for (int i = 0; i < 4; i++) step(1'b1);
        check("t3_settle", int'(est0), 0);
        for (int i = 0; i < 12; i++) begin
            needs = mk((i % 2 == 0) ? 4 : 6, 6, 6, 6, 6);
            step(1'b1);
            check("t3_hold", int'(est0), 0);
            check("t3_nopulse", int'(chg0), 0);
        end

        // 4: resting override, then hold-filtered return.
        resting = 1'b1;
        step(1'b1);
        check("t4_rest", int'(est0), 3);
        resting = 1'b0;
        needs = mk(6, 6, 6, 6, 6);
        for (int i = 0; i < 3; i++) step(1'b1);
        check("t4_tick3", int'(est0), 3);
        step(1'b1);
        check("t4_tick4", int'(est0), 0);

        // 5: immediate and sticky death, cleared only by reset.
        needs = mk(1, 1, 1, 1, 7);
        step(1'b1);
        check("t5_death_h4", int'(est0), 10);
        check("t5_death_h1", int'(est1), 10);
        needs = mk(7, 7, 7, 7, 7);
        resting = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1);
        check("t5_sticky", int'(est0), 10);
        check("t5_mask_live", int'(lm0), 0);
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
        resting = 1'b0;
        check("t5_rst_h4", int'(est0), 0);
        check("t5_rst_h1", int'(est1), 0);

        // 6: depression then desolation.
        needs = mk(4, 4, 6, 6, 6);
        step(1'b1);
        check("t6_depr_h1", int'(est1), 9);
        for (int i = 0; i < 3; i++) step(1'b1);
        check("t6_depr_h4", int'(est0), 9);
        needs = mk(2, 2, 2, 6, 6);
        step(1'b1);
        check("t6_desol_h1", int'(est1), 8);
        for (int i = 0; i < 3; i++) step(1'b1);
        check("t6_desol_h4", int'(est0), 8);

        // Randomized soak with slowly changing needs.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom % 5 == 0) begin
                for (int i = 0; i < NN; i++) begin
                    if ($urandom % 3 == 0) needs[i*W +: W] = 3'($urandom_range(0, 4));
                    else needs[i*W +: W] = 3'($urandom_range(4, 7));
                end
            end
            resting = ($urandom % 25 == 0);
            rst     = ($urandom % 150 == 0);
            step($urandom % 4 != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
